btb_update_queue: RTL and testbench
===================================

BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

Interface
REQ-001 Parameter XLEN, default 32, datapath/address width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-003 The block SHALL be clocked by a single clock and SHALL use an asynchronous, active-low reset.
REQ-004 i_clk  in  1  clock, all state on rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_res_valid  in  1  EX has a resolved branch/jump.
REQ-007 o_res_ready  out  1  queue can accept; equals !full.
REQ-008 i_res_pc  in  XLEN  PC of resolved instruction.
REQ-009 i_res_target  in  XLEN  actual target.
REQ-010 i_res_fallthrough  in  XLEN  sequential PC (pc+2 or pc+4).
REQ-011 i_res_taken  in  1  actual outcome.
REQ-012 i_res_pred_taken  in  1  IF prediction carried down pipe.
REQ-013 i_res_pred_target  in  XLEN  IF predicted target.
REQ-014 o_mispredict  out  1  one-cycle redirect pulse.
REQ-015 o_redirect_pc  out  XLEN  correct next PC, valid with o_mispredict.
REQ-016 i_drain_en  in  1  BTB write port free this cycle.
REQ-017 o_update  out  1  BTB update strobe.
REQ-018 o_update_pc / o_update_target  out  XLEN each  head entry fields.
REQ-019 o_update_taken  out  1  head entry outcome.
REQ-020 o_count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-021 Accept (push) SHALL occur at a rising edge where i_res_valid && o_res_ready.
REQ-022 o_res_ready SHALL be registered-state only (!full), with no combinational path from i_drain_en or i_res_valid.
REQ-023 Mispredict condition SHALL be (taken != pred_taken) || (taken && pred_taken && target != pred_target).
REQ-024 o_mispredict SHALL be a registered output: high for exactly the one cycle after an accept whose mispredict condition held; low otherwise.
REQ-025 o_redirect_pc SHALL be registered with o_mispredict: target if taken, else fallthrough; it SHALL hold its last value when o_mispredict is low.
REQ-026 i_res_valid without accept (full) SHALL produce no mispredict, push or state change.
REQ-027 Every accepted resolution SHALL be enqueued {pc, target, taken}, mispredicted or not.
REQ-028 o_update SHALL equal (count != 0) && i_drain_en; o_update_* SHALL show the head entry combinationally.
REQ-029 Pop SHALL occur at a rising edge where o_update is high.
REQ-030 FIFO order SHALL be strict: updates leave in acceptance order.
REQ-031 No bypass: a pushed entry SHALL reach o_update no earlier than the cycle after its accept.
REQ-032 Read/write pointers SHALL wrap modulo DEPTH; count SHALL be in the range 0..DEPTH.
REQ-033 Simultaneous push and pop SHALL leave count unchanged and SHALL be legal at any occupancy below full.
REQ-034 Push-only SHALL increment count; pop-only SHALL decrement count; neither SHALL leave count unchanged.
REQ-035 Overflow and underflow SHALL be impossible by construction: push is gated by ready, and pop is gated by count != 0.

Reset
REQ-036 Asserting i_rst_n low SHALL asynchronously clear the pointers and count, and drive o_mispredict=0 and o_res_ready=1, regardless of clock.
REQ-037 While reset is asserted, o_update SHALL be 0 and o_redirect_pc SHALL be 0.
REQ-038 Entry storage SHALL NOT require reset.
REQ-039 Reset asserted mid-operation SHALL discard all queued entries and any pending mispredict pulse.
REQ-040 Deassertion SHALL take effect at the next rising edge, which SHALL begin normal operation with an empty queue.

Verification
REQ-041 Correct prediction -> no redirect:
  - Stimulus: accept pc=0x100, taken=1, pred_taken=1, target=pred_target=0x200.
  - Response: o_mispredict stays 0; next cycle, with drain_en=1, o_update=1, pc=0x100, target=0x200, taken=1.
REQ-042 Direction mispredict -> redirect to fallthrough:
  - Stimulus: accept pc=0x104, taken=0, pred_taken=1, fallthrough=0x108.
  - Response: one cycle later o_mispredict=1 for one cycle with o_redirect_pc=0x108.
REQ-043 Target mispredict -> redirect to actual target:
  - Stimulus: taken=1, pred_taken=1, target=0x300, pred_target=0x240.
  - Response: o_mispredict=1, o_redirect_pc=0x300.
REQ-044 Fill, stall, then drain in order:
  - Stimulus: drain_en=0, push 4 entries; then a 5th valid.
  - Response: after 4 pushes o_res_ready=0 and o_count=4; the 5th causes no change and no mispredict; with drain_en=1, four updates emerge in order on consecutive cycles, and o_res_ready=1 after the first pop.
REQ-045 Steady push/pop:
  - Stimulus: at count=2, push and pop in the same cycle for 10 cycles.
  - Response: count stays 2 and pointers wrap correctly (entries match).
REQ-046 Async reset mid-operation:
  - Stimulus: count=3 with a mispredict pulse pending; assert i_rst_n=0 between clock edges.
  - Response: o_count=0, o_update=0, o_mispredict=0 immediately; no stale entry appears after release.

Source files
------------

// File: rtl/btb_update_queue_if.sv
// rtl/btb_update_queue_if.sv - resolution, redirect and BTB update channels of the update queue
interface btb_update_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Resolution channel from EX
  logic            i_res_valid;
  logic            o_res_ready;
  logic [XLEN-1:0] i_res_pc;
  logic [XLEN-1:0] i_res_target;
  logic [XLEN-1:0] i_res_fallthrough;
  logic            i_res_taken;
  logic            i_res_pred_taken;
  logic [XLEN-1:0] i_res_pred_target;

  // Redirect back to fetch
  logic            o_mispredict;
  logic [XLEN-1:0] o_redirect_pc;

  // BTB write channel
  logic            i_drain_en;
  logic            o_update;
  logic [XLEN-1:0] o_update_pc;
  logic [XLEN-1:0] o_update_target;
  logic            o_update_taken;
  logic [CW-1:0]   o_count;

  modport slave (
    input  i_res_valid, i_res_pc, i_res_target, i_res_fallthrough,
    input  i_res_taken, i_res_pred_taken, i_res_pred_target, i_drain_en,
    output o_res_ready, o_mispredict, o_redirect_pc,
    output o_update, o_update_pc, o_update_target, o_update_taken, o_count
  );

  modport master (
    output i_res_valid, i_res_pc, i_res_target, i_res_fallthrough,
    output i_res_taken, i_res_pred_taken, i_res_pred_target, i_drain_en,
    input  o_res_ready, o_mispredict, o_redirect_pc,
    input  o_update, o_update_pc, o_update_target, o_update_taken, o_count
  );
endinterface

// File: rtl/btb_update_queue.sv
// rtl/btb_update_queue.sv - branch resolution queue: mispredict redirect plus in-order BTB update FIFO
module btb_update_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  btb_update_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            push;
  logic            pop;
  logic            mispredict_c;
  logic            mispredict_q;
  logic [XLEN-1:0] redirect_q;

  logic [XLEN-1:0] mem_pc     [DEPTH];
  logic [XLEN-1:0] mem_target [DEPTH];
  logic [DEPTH-1:0] mem_taken;

  // ready depends only on stored occupancy, never on this cycle's inputs
  assign full            = (count == CW'(DEPTH));
  assign bus.o_res_ready = !full;

  // a rejected valid (queue full) has no side effects at all
  assign push = bus.i_res_valid && !full;
  // pop gated by occupancy so an empty queue can never underflow
  assign pop  = (count != '0) && bus.i_drain_en;

  // wrong direction, or right "taken" direction with a wrong target
  assign mispredict_c = (bus.i_res_taken != bus.i_res_pred_taken) ||
                        (bus.i_res_taken && bus.i_res_pred_taken &&
                         (bus.i_res_target != bus.i_res_pred_target));

  // pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // one-cycle redirect pulse after a mispredicted accept; redirect pc holds between pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= push && mispredict_c;
      if (push && mispredict_c) begin
        redirect_q <= bus.i_res_taken ? bus.i_res_target : bus.i_res_fallthrough;
      end
    end
  end

  // entry storage needs no reset: only slots covered by count are ever presented
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_pc[wr_ptr]     <= bus.i_res_pc;
      mem_target[wr_ptr] <= bus.i_res_target;
      mem_taken[wr_ptr]  <= bus.i_res_taken;
    end
  end

  assign bus.o_mispredict    = mispredict_q;
  assign bus.o_redirect_pc   = redirect_q;
  // head entry is read straight from storage, so a fresh push appears only after its edge
  assign bus.o_update        = pop;
  assign bus.o_update_pc     = mem_pc[rd_ptr];
  assign bus.o_update_target = mem_target[rd_ptr];
  assign bus.o_update_taken  = mem_taken[rd_ptr];
  assign bus.o_count         = count;
endmodule

// File: tb/tb_btb_update_queue.sv
// tb/tb_btb_update_queue.sv - randomized and directed self-checking bench for btb_update_queue
module tb_btb_update_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  btb_update_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  btb_update_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted resolutions plus the expected redirect
  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } entry_t;

  entry_t          mq[$];
  logic            m_mp;
  logic [XLEN-1:0] m_rpc;

  always @(posedge clk or negedge rst_n) begin
    bit acc, drn, wrong;
    if (!rst_n) begin
      mq.delete();
      m_mp  = 1'b0;
      m_rpc = '0;
    end else begin
      acc   = bus.i_res_valid && (mq.size() < DEPTH);
      drn   = (mq.size() != 0) && bus.i_drain_en;
      wrong = (bus.i_res_taken != bus.i_res_pred_taken) ||
              (bus.i_res_taken && bus.i_res_target != bus.i_res_pred_target);
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back('{bus.i_res_pc, bus.i_res_target, bus.i_res_taken});
      m_mp = acc && wrong;
      if (m_mp) m_rpc = bus.i_res_taken ? bus.i_res_target : bus.i_res_fallthrough;
    end
  end

  // Compare every cycle on the falling edge, where inputs and outputs are stable
  always @(negedge clk) begin
    chk("cmp_count", 64'(bus.o_count), 64'(mq.size()));
    chk("cmp_ready", 64'(bus.o_res_ready), 64'(mq.size() < DEPTH));
    chk("cmp_update", 64'(bus.o_update), 64'((mq.size() != 0) && bus.i_drain_en));
    chk("cmp_mispredict", 64'(bus.o_mispredict), 64'(m_mp));
    chk("cmp_redirect_pc", 64'(bus.o_redirect_pc), 64'(m_rpc));
    if (mq.size() != 0) begin
      chk("cmp_update_pc", 64'(bus.o_update_pc), 64'(mq[0].pc));
      chk("cmp_update_target", 64'(bus.o_update_target), 64'(mq[0].target));
      chk("cmp_update_taken", 64'(bus.o_update_taken), 64'(mq[0].taken));
    end
  end

  task automatic set_res(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                         input logic [XLEN-1:0] ft, input logic tk, input logic ptk,
                         input logic [XLEN-1:0] ptgt);
    bus.i_res_valid       = v;
    bus.i_res_pc          = pc;
    bus.i_res_target      = tgt;
    bus.i_res_fallthrough = ft;
    bus.i_res_taken       = tk;
    bus.i_res_pred_taken  = ptk;
    bus.i_res_pred_target = ptgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.i_drain_en = 1'b1;
    set_res(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    #2;
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_ready", 64'(bus.o_res_ready), 64'd1);
    chk("rst_update", 64'(bus.o_update), 64'd0);
    chk("rst_mispredict", 64'(bus.o_mispredict), 64'd0);
    chk("rst_redirect", 64'(bus.o_redirect_pc), 64'd0);
    #10 rst_n = 1'b1;
    step();

    // correct prediction: no redirect, entry visible only after the accept edge
    set_res(1'b1, 32'h100, 32'h200, 32'h104, 1'b1, 1'b1, 32'h200);
    #1;
    chk("nobypass_update", 64'(bus.o_update), 64'd0);
    step();
    set_res(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("good_mispredict", 64'(bus.o_mispredict), 64'd0);
    chk("good_update", 64'(bus.o_update), 64'd1);
    chk("good_pc", 64'(bus.o_update_pc), 64'h100);
    chk("good_target", 64'(bus.o_update_target), 64'h200);
    chk("good_taken", 64'(bus.o_update_taken), 64'd1);
    step();

    // direction mispredict redirects to fallthrough, pulse lasts one cycle, pc holds
    set_res(1'b1, 32'h104, 32'h180, 32'h108, 1'b0, 1'b1, 32'h180);
    step();
    set_res(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("dir_mispredict", 64'(bus.o_mispredict), 64'd1);
    chk("dir_redirect", 64'(bus.o_redirect_pc), 64'h108);
    step();
    chk("dir_pulse_end", 64'(bus.o_mispredict), 64'd0);
    chk("dir_redirect_hold", 64'(bus.o_redirect_pc), 64'h108);

    // target mispredict redirects to actual target
    set_res(1'b1, 32'h110, 32'h300, 32'h114, 1'b1, 1'b1, 32'h240);
    step();
    set_res(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("tgt_mispredict", 64'(bus.o_mispredict), 64'd1);
    chk("tgt_redirect", 64'(bus.o_redirect_pc), 64'h300);
    repeat (3) step();

    // fill to full with draining off, then a rejected fifth valid
    bus.i_drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_res(1'b1, 32'h400 + 32'(4 * i), 32'h500 + 32'(i), 32'h404 + 32'(4 * i), 1'(i), 1'(i), 32'h500 + 32'(i));
      step();
    end
    chk("full_count", 64'(bus.o_count), 64'd4);
    chk("full_ready", 64'(bus.o_res_ready), 64'd0);
    set_res(1'b1, 32'h999, 32'h777, 32'h99d, 1'b1, 1'b0, 32'h0);
    step();
    set_res(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("reject_count", 64'(bus.o_count), 64'd4);
    chk("reject_mispredict", 64'(bus.o_mispredict), 64'd0);
    bus.i_drain_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("drain_update", 64'(bus.o_update), 64'd1);
      chk("drain_pc", 64'(bus.o_update_pc), 64'h400 + 64'(4 * i));
      step();
      if (i == 0) chk("drain_ready", 64'(bus.o_res_ready), 64'd1);
    end
    chk("drain_empty", 64'(bus.o_count), 64'd0);

    // steady push/pop at occupancy two across pointer wrap
    bus.i_drain_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_res(1'b1, 32'h600 + 32'(4 * i), 32'h700, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
    end
    bus.i_drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_res(1'b1, 32'h608 + 32'(4 * i), 32'h700, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("steady_head", 64'(bus.o_update_pc), 64'h600 + 64'(4 * i));
      step();
      chk("steady_count", 64'(bus.o_count), 64'd2);
    end
    set_res(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    repeat (3) step();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_res(1'($urandom_range(0, 2) != 0), $urandom, 32'h200 + 32'(4 * $urandom_range(0, 1)),
              $urandom, 1'($urandom), 1'($urandom), 32'h200 + 32'(4 * $urandom_range(0, 1)));
      bus.i_drain_en = 1'($urandom_range(0, 2) == 0 ? 0 : $urandom);
      step();
    end

    // async reset with three entries queued and a redirect pulse pending
    set_res(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    bus.i_drain_en = 1'b1;
    repeat (6) step();
    bus.i_drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_res(1'b1, 32'h800 + 32'(4 * i), 32'h900, 32'h804 + 32'(4 * i), 1'(i == 2), 1'b0, 32'h0);
      step();
    end
    set_res(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("pre_rst_count", 64'(bus.o_count), 64'd3);
    chk("pre_rst_mispredict", 64'(bus.o_mispredict), 64'd1);
    bus.i_drain_en = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_count", 64'(bus.o_count), 64'd0);
    chk("async_update", 64'(bus.o_update), 64'd0);
    chk("async_mispredict", 64'(bus.o_mispredict), 64'd0);
    chk("async_redirect", 64'(bus.o_redirect_pc), 64'd0);
    step();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_update", 64'(bus.o_update), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
